asynchronous_fifo: RTL and testbench



---
 rtl/asynchronous_fifo_if.sv | 29 ++
 rtl/asynchronous_fifo.sv | 52 +++++
 tb/tb_asynchronous_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/asynchronous_fifo_if.sv
// rtl/asynchronous_fifo_if.sv - push/pop handshake and status bundle for the FWFT FIFO
interface asynchronous_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  fifo_full;
    logic                  fifo_empty;

    modport master (
        output wr_en,
        output rd_en,
        output data_in,
        input  data_out,
        input  fifo_full,
        input  fifo_empty
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  data_in,
        output data_out,
        output fifo_full,
        output fifo_empty
    );
endinterface

// File: rtl/asynchronous_fifo.sv
// rtl/asynchronous_fifo.sv - single-clock first-word-fall-through FIFO with wrap-flag pointers
module asynchronous_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wrclk,
    input  logic                  wrrst_n,
    asynchronous_fifo_if.slave    fifo
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // The pointer MSB toggles on each pass through memory, separating full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_push  = fifo.wr_en && !w_full;
    assign w_pop   = fifo.rd_en && !w_empty;

    always_ff @(posedge wrclk) begin
        if (!wrrst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is left uninitialised by reset; the empty flag masks stale words.
    always_ff @(posedge wrclk) begin
        if (wrrst_n && w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= fifo.data_in;
        end
    end

    assign fifo.fifo_full  = w_full;
    assign fifo.fifo_empty = w_empty;
    assign fifo.data_out   = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
endmodule

// File: tb/tb_asynchronous_fifo.sv
// tb/tb_asynchronous_fifo.sv - directed self-checking bench for asynchronous_fifo
module tb_asynchronous_fifo;
    logic wrclk = 1'b0;
    logic wrrst_n;
    int   total = 0;
    int   bad   = 0;

    asynchronous_fifo_if #(.DATA_WIDTH(8)) bus ();

    asynchronous_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .wrclk   (wrclk),
        .wrrst_n (wrrst_n),
        .fifo    (bus.slave)
    );

    always #5 wrclk = ~wrclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] rnd;

    initial begin
        wrrst_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = 8'h00;

        // 1: reset and idle
        repeat (10) tick();
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_full",  32'(bus.fifo_full),  32'd0);
        chk("rst_dout",  32'(bus.data_out),   32'h0);
        wrrst_n = 1'b1;
        repeat (3) tick();
        chk("idle_empty", 32'(bus.fifo_empty), 32'd1);
        chk("idle_full",  32'(bus.fifo_full),  32'd0);

        // 2: single word fall-through
        bus.wr_en = 1'b1; bus.data_in = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        chk("one_empty", 32'(bus.fifo_empty), 32'd0);
        chk("one_dout",  32'(bus.data_out),   32'hA5);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("one_pop_empty", 32'(bus.fifo_empty), 32'd1);
        chk("one_pop_dout",  32'(bus.data_out),   32'h0);

        // 3: fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.data_in = 8'(i);
            tick();
            if (i == 14) chk("full_at15", 32'(bus.fifo_full), 32'd0);
        end
        chk("full_at16", 32'(bus.fifo_full), 32'd1);
        bus.data_in = 8'hFF;
        tick();
        bus.wr_en = 1'b0;
        chk("ovf_full", 32'(bus.fifo_full), 32'd1);
        chk("ovf_head", 32'(bus.data_out),  32'h00);
        for (int i = 0; i < 16; i++) begin
            chk("drain_dout", 32'(bus.data_out), 32'(i));
            bus.rd_en = 1'b1;
            tick();
        end
        bus.rd_en = 1'b0;
        chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
        chk("drain_dout0", 32'(bus.data_out),   32'h0);

        // 4: alternating push/pop against a scoreboard, three rounds to wrap pointers
        for (int r = 0; r < 3; r++) begin
            int pushed = 0;
            int cyc = 0;
            while ((pushed < 30 || q.size() != 0) && cyc < 200) begin
                bus.wr_en = 1'b0;
                bus.rd_en = 1'b0;
                if ((cyc % 2) == 0 && pushed < 30) begin
                    rnd = 8'($urandom_range(0, 255));
                    bus.wr_en = 1'b1; bus.data_in = rnd;
                    q.push_back(rnd);
                    pushed++;
                end else if ((cyc % 2) == 1 && !bus.fifo_empty) begin
                    exp_b = q.pop_front();
                    chk("sb_dout", 32'(bus.data_out), 32'(exp_b));
                    bus.rd_en = 1'b1;
                end
                tick();
                cyc++;
            end
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
            chk("sb_bound", 32'(cyc < 200), 32'd1);
            chk("sb_pushed", 32'(pushed), 32'd30);
            chk("sb_empty", 32'(bus.fifo_empty), 32'd1);
        end

        // 5: simultaneous push/pop when full, then when empty
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.data_in = 8'(8'h10 + i);
            tick();
        end
        chk("sim_full_pre", 32'(bus.fifo_full), 32'd1);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 8'h77;
        tick();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("sim_full_flag", 32'(bus.fifo_full), 32'd0);
        chk("sim_full_head", 32'(bus.data_out),  32'h11);
        for (int i = 1; i < 16; i++) begin
            chk("sim_drain", 32'(bus.data_out), 32'(8'h10 + i));
            bus.rd_en = 1'b1;
            tick();
        end
        bus.rd_en = 1'b0;
        chk("sim_no77", 32'(bus.fifo_empty), 32'd1);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 8'h77;
        tick();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("sim_empty_flag", 32'(bus.fifo_empty), 32'd0);
        chk("sim_empty_dout", 32'(bus.data_out),   32'h77);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("sim_empty_pop", 32'(bus.fifo_empty), 32'd1);

        // 6: reset mid-operation with a push pending
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.data_in = 8'(8'h30 + i);
            tick();
        end
        chk("mid_head", 32'(bus.data_out), 32'h30);
        wrrst_n = 1'b0; bus.data_in = 8'h99;
        tick();
        wrrst_n = 1'b1; bus.wr_en = 1'b0;
        chk("mid_empty", 32'(bus.fifo_empty), 32'd1);
        chk("mid_full",  32'(bus.fifo_full),  32'd0);
        chk("mid_dout",  32'(bus.data_out),   32'h0);
        bus.wr_en = 1'b1; bus.data_in = 8'h5A;
        tick();
        bus.wr_en = 1'b0;
        chk("post_dout", 32'(bus.data_out), 32'h5A);
        for (int i = 0; i < 15; i++) begin
            bus.wr_en = 1'b1; bus.data_in = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("post_full", 32'(bus.fifo_full), 32'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("post_pop", 32'(bus.data_out), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
